// File: rtl/rr_arbiter_n_pkg.sv
// Shared helpers for the round-robin arbiter: modulo index wrap and
// burst-counter width.
package rr_arb_pkg;

  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_cnt);
    return $clog2(max_cnt + 32'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter_n_if.sv
// Request/pop/mux-select bundle between the ingress FIFOs, the arbiter and
// the shared output mux.
interface rr_arbiter_n_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = 2
) ();
  logic [NUM_CH-1:0] request;
  logic              dst_ready;
  logic [NUM_CH-1:0] pop;
  logic [SEL_W-1:0]  portMux;
  logic              validMux;

  modport master (
    input  request, dst_ready,
    output pop, portMux, validMux
  );

  modport slave (
    output request, dst_ready,
    input  pop, portMux, validMux
  );
endinterface

// File: rtl/rr_arbiter_n_prio_pick.sv
// Combinational rotating-priority picker: first set request bit scanning
// from ptr_i upward with wrap, returned as one-hot grant plus index.
module rr_prio_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [SEL_W-1:0]  idx_o,
  output logic              any_o
);

  always_comb begin
    logic [SEL_W-1:0] pos;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = ptr_i;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      if (!any_o && req_i[pos]) begin
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
        any_o      = 1'b1;
      end
      pos = SEL_W'(next_idx(32'(pos), NUM_CH));
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-channel round-robin FIFO arbiter with downstream backpressure and a
// registered mux select. Define RR_BURST_EN to allow up to MAX_BURST grants in a row.
module rr_arbiter_n
  import rr_arb_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input logic            clk,
  input logic            reset_L,
  rr_arbiter_n_if.master bus
);

  localparam int unsigned BCNT_W = cnt_width(MAX_BURST);

  // With bursts disabled the limit collapses to 1: every grant advances ptr
  // and bcnt stays 0, i.e. plain round robin through the same datapath.
`ifdef RR_BURST_EN
  localparam int unsigned BURST_LIM = MAX_BURST;
`else
  localparam int unsigned BURST_LIM = 1;
`endif

  if (SEL_W != $clog2(NUM_CH)) begin : g_bad_sel_w
    $error("rr_arbiter_n: SEL_W must equal clog2(NUM_CH)");
  end
  if (NUM_CH < 2) begin : g_bad_num_ch
    $error("rr_arbiter_n: NUM_CH must be at least 2");
  end
  if (MAX_BURST < 1) begin : g_bad_burst
    $error("rr_arbiter_n: MAX_BURST must be at least 1");
  end

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  port_q, port_d;
  logic              valid_q, valid_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d, bcnt_n;
  logic [NUM_CH-1:0] gnt;
  logic [SEL_W-1:0]  win;
  logic              any;
  logic              grant;

  rr_prio_pick #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_pick (
    .req_i (bus.request),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win),
    .any_o (any)
  );

  assign grant        = reset_L && bus.dst_ready && any;
  assign bus.pop      = grant ? gnt : '0;
  assign bus.portMux  = port_q;
  assign bus.validMux = valid_q;

  always_comb begin
    port_d  = port_q;
    valid_d = 1'b0;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    bcnt_n  = (win == port_q && bcnt_q != '0) ? bcnt_q + 1'b1 : BCNT_W'(1);
    if (grant) begin
      port_d  = win;
      valid_d = 1'b1;
      if (32'(bcnt_n) < BURST_LIM) begin
        ptr_d  = win;
        bcnt_d = bcnt_n;
      end else begin
        ptr_d  = SEL_W'(next_idx(32'(win), NUM_CH));
        bcnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr_q   <= '0;
      port_q  <= '0;
      valid_q <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      port_q  <= port_d;
      valid_q <= valid_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n: a 4-channel instance (MAX_BURST=2) and a
// 3-channel instance (MAX_BURST=1), expectations hand-computed for both macro settings.
module tb_rr_arbiter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4_n;
    logic rst3_n;
    int   total = 0;
    int   bad   = 0;

    rr_arbiter_n_if #(.NUM_CH(4), .SEL_W(2)) bus4 ();
    rr_arbiter_n_if #(.NUM_CH(3), .SEL_W(2)) bus3 ();

    rr_arbiter_n #(.NUM_CH(4), .SEL_W(2), .MAX_BURST(2)) dut4 (
        .clk     (clk),
        .reset_L (rst4_n),
        .bus     (bus4.master)
    );

    rr_arbiter_n #(.NUM_CH(3), .SEL_W(2), .MAX_BURST(1)) dut3 (
        .clk     (clk),
        .reset_L (rst3_n),
        .bus     (bus3.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle: check pop combinationally, then the registered outputs after the edge.
    task automatic step4(input string tag, input logic [3:0] req, input logic rdy,
                         input logic [3:0] e_pop, input logic [1:0] e_port, input logic e_val);
        bus4.request   = req;
        bus4.dst_ready = rdy;
        #1;
        chk({tag, ".pop"}, 32'(bus4.pop), 32'(e_pop));
        @(posedge clk);
        #1;
        chk({tag, ".port"},  32'(bus4.portMux),  32'(e_port));
        chk({tag, ".valid"}, 32'(bus4.validMux), 32'(e_val));
    endtask

    task automatic step3(input string tag, input logic [2:0] req,
                         input logic [2:0] e_pop, input logic [1:0] e_port, input logic e_val);
        bus3.request   = req;
        bus3.dst_ready = 1'b1;
        #1;
        chk({tag, ".pop"}, 32'(bus3.pop), 32'(e_pop));
        @(posedge clk);
        #1;
        chk({tag, ".port"},  32'(bus3.portMux),  32'(e_port));
        chk({tag, ".valid"}, 32'(bus3.validMux), 32'(e_val));
    endtask

    initial begin
        rst4_n         = 1'b0;
        rst3_n         = 1'b0;
        bus4.request   = 4'b1111;
        bus4.dst_ready = 1'b1;
        bus3.request   = 3'b000;
        bus3.dst_ready = 1'b1;

        // reset held with all channels requesting
        #3;
        chk("rst.pop",   32'(bus4.pop),      32'h0);
        chk("rst.port",  32'(bus4.portMux),  32'h0);
        chk("rst.valid", 32'(bus4.validMux), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_edge.pop",   32'(bus4.pop),      32'h0);
        chk("rst_edge.valid", 32'(bus4.validMux), 32'h0);
        rst4_n = 1'b1;

        // A: all requesting, eight cycles
`ifdef RR_BURST_EN
        step4("A0", 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
        step4("A1", 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
        step4("A2", 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1);
        step4("A3", 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1);
        step4("A4", 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1);
        step4("A5", 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1);
        step4("A6", 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1);
        step4("A7", 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1);
        step4("B0", 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
        step4("B1", 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
        step4("C0", 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1);
        step4("C1", 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1);
`else
        step4("A0", 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
        step4("A1", 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1);
        step4("A2", 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1);
        step4("A3", 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1);
        step4("A4", 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
        step4("A5", 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1);
        step4("A6", 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1);
        step4("A7", 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1);
        // B: move ptr to 2, then C: sparse request wraps 3 -> 1
        step4("B0", 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
        step4("B1", 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1);
        step4("C0", 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1);
        step4("C1", 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1);
`endif

        // D: backpressure for three cycles mid-stream
        step4("D0", 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1);
        step4("D1", 4'b1111, 1'b0, 4'b0000, 2'd2, 1'b0);
        step4("D2", 4'b1111, 1'b0, 4'b0000, 2'd2, 1'b0);
        step4("D3", 4'b1111, 1'b0, 4'b0000, 2'd2, 1'b0);
`ifdef RR_BURST_EN
        step4("D4", 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1);
        step4("D5", 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1);
`else
        step4("D4", 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1);
        step4("D5", 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
`endif

        // E: single requester wins every cycle
        step4("E0", 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1);
        step4("E1", 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1);
        step4("E2", 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1);
        step4("E3", 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1);
        step4("E4", 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1);

        // async reset between edges clears everything at once
        bus4.request = 4'b1111;
        rst4_n       = 1'b0;
        #1;
        chk("R4.pop",   32'(bus4.pop),      32'h0);
        chk("R4.port",  32'(bus4.portMux),  32'h0);
        chk("R4.valid", 32'(bus4.validMux), 32'h0);
        #2;
        rst4_n = 1'b1;

        // F: two requesters from a clean pointer
`ifdef RR_BURST_EN
        step4("F0", 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1);
        step4("F1", 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1);
        step4("F2", 4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1);
        step4("F3", 4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1);
        step4("F4", 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1);
`else
        step4("F0", 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1);
        step4("F1", 4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1);
        step4("F2", 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1);
        step4("F3", 4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1);
        step4("F4", 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1);
`endif
        step4("G0", 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
        bus4.request = 4'b0000;

        // 3-channel instance: non-power-of-two wrap and mid-stream reset
        rst3_n = 1'b1;
        step3("N0", 3'b111, 3'b001, 2'd0, 1'b1);
        step3("N1", 3'b111, 3'b010, 2'd1, 1'b1);
        step3("N2", 3'b111, 3'b100, 2'd2, 1'b1);
        step3("N3", 3'b111, 3'b001, 2'd0, 1'b1);
        step3("N4", 3'b111, 3'b010, 2'd1, 1'b1);
        rst3_n = 1'b0;
        #1;
        chk("R3.pop",   32'(bus3.pop),      32'h0);
        chk("R3.port",  32'(bus3.portMux),  32'h0);
        chk("R3.valid", 32'(bus3.validMux), 32'h0);
        #2;
        rst3_n = 1'b1;
        step3("N5", 3'b111, 3'b001, 2'd0, 1'b1);
        step3("N6", 3'b110, 3'b010, 2'd1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
